// File: rtl/ctr_encryption.sv
// Purpose : AES-256 CTR-mode encryption of a 1024-bit (8 x 128-bit) message.
// Latency : 121 cycles from LOAD to DONE (1 load + 8 blocks x 15 rounds).
// Backpressure: none; inputs are level-sampled, DONE re-runs when they change.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst           asynchronous active-high reset
//   plaintext_in  eight 128-bit blocks, block 0 at [1023:896]
//   key           AES-256 key, FIPS-197 byte 0 at [255:248]
//   iv            initial counter block, byte 0 at [127:120]
//   text          [1023:0] ciphertext (block i aligned with plaintext block i),
//                 [1999:1024] tied to zero
module ctr_encryption (
    input  logic          clk,
    input  logic          rst,
    input  logic [1023:0] plaintext_in,
    input  logic [255:0]  key,
    input  logic [127:0]  iv,
    output logic [1999:0] text
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // Entry x lives at bit offset (255 - x) * 8, and 255 - x == ~x.
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Rcon for the expansion step executed in round r. Odd rounds produce
    // words whose index is a multiple of 8; word index / 8 == (r + 1) / 2.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd3:    rc = 8'h02;
            4'd5:    rc = 8'h04;
            4'd7:    rc = 8'h08;
            4'd9:    rc = 8'h10;
            4'd11:   rc = 8'h20;
            4'd13:   rc = 8'h40;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_fsm;
    state_t          w_fsm_nxt;

    logic [1023:0]   r_pt_sh;
    logic [255:0]    r_key_sh;
    logic [127:0]    r_iv_sh;
    logic [2:0]      r_blk;
    logic [3:0]      r_round;
    logic [127:0]    r_aes;
    // Sliding key-schedule window: during round r (r >= 1) it holds
    // w[4r-4 .. 4r+3], so the round key w[4r .. 4r+3] is the low half.
    logic [255:0]    r_kw;
    logic [1023:0]   r_acc;
    logic [1023:0]   r_text;

    logic [127:0]    w_ctr;
    logic [127:0]    w_pt_blk;
    logic [127:0]    w_sb;
    logic [127:0]    w_sr;
    logic [127:0]    w_mc;
    logic [127:0]    w_rk;
    logic [127:0]    w_round_out;
    logic [127:0]    w_ct;
    logic [31:0]     w_kw_tmp;
    logic [127:0]    w_kw_new;
    logic [1023:0]   w_acc_nxt;
    logic            w_last_round;
    logic            w_last_block;
    logic            w_inputs_changed;

    assign text = {976'd0, r_text};

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    assign w_ctr        = r_iv_sh + {125'd0, r_blk};
    // Block b sits at bit offset (7 - b) * 128 == {~b, 7'b0}.
    assign w_pt_blk     = r_pt_sh[{~r_blk, 7'b0} +: 128];
    assign w_rk         = r_kw[127:0];
    assign w_last_round = (r_round == 4'd14);
    assign w_last_block = (r_blk == 3'd7);

    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int i = 0; i < 16; i++) begin
            w_sb[8*(15-i) +: 8] = sbox(r_aes[8*(15-i) +: 8]);
        end
        // ShiftRows: row r of column c takes row r of column (c + r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[8*(15-(4*c+r)) +: 8] = w_sb[8*(15-(4*((c+r)%4)+r)) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[32*(3-c) +: 32] = mix_col(w_sr[32*(3-c) +: 32]);
        end
    end

    // Final round skips MixColumns.
    assign w_round_out = (w_last_round ? w_sr : w_mc) ^ w_rk;
    assign w_ct        = w_pt_blk ^ w_round_out;

    // ------------------------------------------------------------------
    // On-the-fly key expansion: four new words per round
    // ------------------------------------------------------------------
    always_comb begin
        w_kw_tmp = '0;
        if (r_round[0]) begin
            w_kw_tmp = sub_word({r_kw[23:0], r_kw[31:24]}) ^ {rcon(r_round), 24'h0};
        end else begin
            w_kw_tmp = sub_word(r_kw[31:0]);
        end
        w_kw_new[127:96] = r_kw[255:224] ^ w_kw_tmp;
        w_kw_new[95:64]  = r_kw[223:192] ^ w_kw_new[127:96];
        w_kw_new[63:32]  = r_kw[191:160] ^ w_kw_new[95:64];
        w_kw_new[31:0]   = r_kw[159:128] ^ w_kw_new[63:32];
    end

    // Accumulator with the current ciphertext block merged in; also the
    // value published to text when the last block completes, so all
    // 1024 bits change on the same edge.
    always_comb begin
        w_acc_nxt = r_acc;
        w_acc_nxt[{~r_blk, 7'b0} +: 128] = w_ct;
    end

    assign w_inputs_changed = (plaintext_in != r_pt_sh) ||
                              (key          != r_key_sh) ||
                              (iv           != r_iv_sh);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= LOAD;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            LOAD:    w_fsm_nxt = RUN;
            RUN:     if (w_last_round && w_last_block) w_fsm_nxt = DONE;
            DONE:    if (w_inputs_changed) w_fsm_nxt = LOAD;
            default: w_fsm_nxt = LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pt_sh  <= '0;
            r_key_sh <= '0;
            r_iv_sh  <= '0;
            r_blk    <= '0;
            r_round  <= '0;
            r_aes    <= '0;
            r_kw     <= '0;
            r_acc    <= '0;
            r_text   <= '0;
        end else begin
            case (r_fsm)
                LOAD: begin
                    r_pt_sh  <= plaintext_in;
                    r_key_sh <= key;
                    r_iv_sh  <= iv;
                    r_blk    <= '0;
                    r_round  <= '0;
                end
                RUN: begin
                    if (r_round == 4'd0) begin
                        // Initial AddRoundKey: round key 0 is key bytes 0..15.
                        r_aes   <= w_ctr ^ r_key_sh[255:128];
                        r_kw    <= r_key_sh;
                        r_round <= 4'd1;
                    end else begin
                        r_aes <= w_round_out;
                        r_kw  <= {r_kw[127:0], w_kw_new};
                        if (w_last_round) begin
                            r_acc   <= w_acc_nxt;
                            r_round <= 4'd0;
                            r_blk   <= r_blk + 3'd1;
                            if (w_last_block) begin
                                r_text <= w_acc_nxt;
                            end
                        end else begin
                            r_round <= r_round + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_encryption.sv
// Bench for ctr_encryption: independent AES-256 CTR reference, vector table
// and hand-written timing sequences (restart, reset abort, late input change).
module tb_ctr_encryption;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] plaintext_in;
    logic [255:0]  key;
    logic [127:0]  iv;
    logic [1999:0] text;

    always #5 clk = ~clk;

    ctr_encryption dut (
        .clk          (clk),
        .rst          (rst),
        .plaintext_in (plaintext_in),
        .key          (key),
        .iv           (iv),
        .text         (text)
    );

    typedef struct {
        logic [1023:0] pt;
        logic [255:0]  key;
        logic [127:0]  iv;
        int            kat_n;   // number of leading blocks with known answers
        logic [127:0]  kat0;
        logic [127:0]  kat1;
    } vec_t;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [7:0]    tb_sb [256];
    logic [1023:0] exp_q [$];
    logic [1023:0] held;
    logic [1023:0] saved [7];
    vec_t          vt [7];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] xb;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, xb);
            tb_sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                       {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes256(input logic [255:0] k, input logic [127:0] pin);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = {tb_sb[tmp[23:16]], tb_sb[tmp[15:8]], tb_sb[tmp[7:0]], tb_sb[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = {tb_sb[tmp[31:24]], tb_sb[tmp[23:16]], tb_sb[tmp[15:8]], tb_sb[tmp[7:0]]};
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pin[127-8*j -: 8];
        for (int r = 0; r < 15; r++) begin
            if (r > 0) begin
                for (int j = 0; j < 16; j++) t[j] = tb_sb[s[j]];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++)
                        s[4*c+row] = t[4*((c+row)%4)+row];
                if (r < 14) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = s[4*c+row] ^ w[4*r+c][31-8*row -: 8];
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    function automatic logic [1023:0] model_text(input logic [1023:0] pt,
                                                 input logic [255:0] k,
                                                 input logic [127:0] v);
        logic [1023:0] res;
        logic [127:0]  ctr;
        ctr = v;
        for (int b = 0; b < 8; b++) begin
            res[1023-128*b -: 128] = pt[1023-128*b -: 128] ^ aes256(k, ctr);
            ctr = ctr + 128'd1;
        end
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1024(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        int first;
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            first = -1;
            for (int k = 0; k < 8; k++)
                if (first < 0 && act[1023-128*k -: 128] !== exp[1023-128*k -: 128]) first = k;
            if (first < 0) first = 0;
            $display("FAIL %s: block %0d got %h expected %h", nm, first,
                     act[1023-128*first -: 128], exp[1023-128*first -: 128]);
        end
    endtask

    task automatic chk_upper(input string nm);
        n_checks++;
        if (text[1999:1024] !== '0) begin
            n_errors++;
            $display("FAIL %s: upper text has %0d set bits, required 0", nm,
                     $countones(text[1999:1024]));
        end
    endtask

    task automatic apply(input logic [1023:0] pt, input logic [255:0] k, input logic [127:0] v);
        plaintext_in = pt;
        key          = k;
        iv           = v;
        exp_q.push_back(model_text(pt, k, v));
    endtask

    task automatic sb_check(input string nm);
        logic [1023:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty when result expected", nm);
        end else begin
            e = exp_q.pop_front();
            chk1024(nm, text[1023:0], e);
            held = e;
        end
    endtask

    // Inputs changed just after an edge: old text for 121 edges, new on the 122nd.
    task automatic run_change(input string nm, input int idx);
        apply(vt[idx].pt, vt[idx].key, vt[idx].iv);
        tick(121);
        chk1024({nm, "_hold"}, text[1023:0], held);
        tick(1);
        sb_check(nm);
        chk_upper({nm, "_upper"});
        saved[idx] = text[1023:0];
        if (vt[idx].kat_n > 0) chk128({nm, "_kat0"}, text[1023:896], vt[idx].kat0);
        if (vt[idx].kat_n > 1) chk128({nm, "_kat1"}, text[895:768], vt[idx].kat1);
    endtask

    initial begin
        build_sbox();

        vt[0] = '{pt: '0, key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  iv: 128'h00112233445566778899aabbccddeeff, kat_n: 1,
                  kat0: 128'h8ea2b7ca516745bfeafc49904b496089, kat1: '0};
        vt[1] = '{pt: {128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 768'h0},
                  key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                  iv: 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, kat_n: 2,
                  kat0: 128'h601ec313775789a5b7a7f504bbf3d228, kat1: 128'hf443e3ca4d62b59aca84e990cacaf5c5};
        vt[2] = '{pt: {16{64'hdeadbeef0badf00d}}, key: vt[1].key, iv: vt[1].iv, kat_n: 0, kat0: '0, kat1: '0};
        vt[3] = '{pt: '0, key: vt[1].key, iv: vt[1].iv, kat_n: 0, kat0: '0, kat1: '0};
        vt[4] = '{pt: '0, key: vt[1].key, iv: {128{1'b1}}, kat_n: 0, kat0: '0, kat1: '0};
        vt[5] = '{pt: '0, key: vt[1].key, iv: {64'h0123456789abcdef, 64'hfffffffffffffffd},
                  kat_n: 0, kat0: '0, kat1: '0};
        vt[6] = '{pt: '0, key: {8{32'h5a5aa5a5}}, iv: vt[5].iv, kat_n: 0, kat0: '0, kat1: '0};

        // Reset state
        rst = 1'b1;
        apply(vt[0].pt, vt[0].key, vt[0].iv);
        tick(3);
        chk1024("reset_text", text[1023:0], '0);
        chk_upper("reset_upper");

        // First result 121 edges after release
        rst = 1'b0;
        tick(120);
        chk1024("prevalid_zero", text[1023:0], '0);
        tick(1);
        sb_check("c3_vec");
        chk_upper("c3_upper");
        chk128("c3_kat0", text[1023:896], vt[0].kat0);

        // Table: each entry changes pt, iv or key relative to the previous one
        for (int i = 1; i < 7; i++) run_change($sformatf("vec%0d", i), i);

        // Linearity: same key/iv, X versus zero plaintext
        chk1024("linearity", saved[2] ^ saved[3], vt[2].pt);
        // Counter wrap: blocks 0 and 1 encrypt all-ones then all-zeros
        chk128("wrap_blk0", saved[4][1023:896], aes256(vt[4].key, {128{1'b1}}));
        chk128("wrap_blk1", saved[4][895:768], aes256(vt[4].key, 128'h0));

        // Key change mid-RUN: run finishes on the shadowed key, then restarts
        apply({8{128'h00112233445566778899aabbccddeeff}}, vt[0].key, vt[1].iv);
        tick(40);
        apply(plaintext_in, vt[1].key, iv);
        tick(81);
        chk1024("midrun_hold", text[1023:0], held);
        tick(1);
        sb_check("midrun_old_key");
        tick(121);
        chk1024("midrun_restart_hold", text[1023:0], held);
        tick(1);
        sb_check("midrun_new_key");

        // Input change in the cycle DONE is entered
        apply({16{64'h0f1e2d3c4b5a6978}}, key, iv);
        tick(121);
        chk1024("edge_hold", text[1023:0], held);
        apply(plaintext_in, key, 128'h1);
        tick(1);
        sb_check("edge_first");
        tick(121);
        chk1024("edge_restart_hold", text[1023:0], held);
        tick(1);
        sb_check("edge_second");

        // Reset 50 cycles into a run clears text at once
        apply({8{128'hcafef00d00000000ffffffff12345678}}, vt[6].key, vt[0].iv);
        tick(50);
        chk1024("prereset_hold", text[1023:0], held);
        rst = 1'b1;
        #1;
        chk1024("midrun_reset_clear", text[1023:0], '0);
        tick(2);
        rst = 1'b0;
        tick(120);
        chk1024("postreset_zero", text[1023:0], '0);
        tick(1);
        sb_check("postreset_result");
        chk_upper("postreset_upper");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
